// File: rtl/dmac_fifo_pkg.sv
// rtl/dmac_fifo_pkg.sv - status codes shared by the DMAC FIFO block
package dmac_fifo_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'b000,
    ST_WRITE    = 3'b001,
    ST_READ     = 3'b010,
    ST_WR_ERROR = 3'b011,
    ST_RD_ERROR = 3'b100,
    ST_WR_RD    = 3'b101
  } fifo_state_e;

endpackage

// File: rtl/dmac_fifo_param_if.sv
// rtl/dmac_fifo_param_if.sv - writer/reader handshake and status bundle of the DMAC FIFO
interface dmac_fifo_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) ();

  logic                              wr_en;
  logic [DATA_WIDTH-1:0]             din;
  logic                              rd_en;
  logic [DATA_WIDTH-1:0]             dout;
  logic [ADDR_WIDTH:0]               data_count;
  logic                              full;
  logic                              empty;
  logic                              almost_full;
  logic                              almost_empty;
  logic                              wr_ack;
  logic                              wr_err;
  logic                              rd_ack;
  logic                              rd_err;
  logic [dmac_fifo_pkg::STATE_W-1:0] state;

  // Engines on either side of the FIFO
  modport master (
    output wr_en, din, rd_en,
    input  dout, data_count, full, empty, almost_full, almost_empty,
    input  wr_ack, wr_err, rd_ack, rd_err, state
  );

  // The FIFO itself
  modport slave (
    input  wr_en, din, rd_en,
    output dout, data_count, full, empty, almost_full, almost_empty,
    output wr_ack, wr_err, rd_ack, rd_err, state
  );

endinterface

// File: rtl/dmac_fifo_ram.sv
// rtl/dmac_fifo_ram.sv - DEPTH x DATA_WIDTH storage with registered read-before-write port
module dmac_fifo_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  input  logic                  bypass_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage write; contents are deliberately left uninitialised by reset
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Registered read; samples the pre-edge slot so a same-slot write is seen next time
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= bypass_i ? wdata_i : mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmac_fifo_param.sv
// rtl/dmac_fifo_param.sv - parametrised DMAC FIFO; DMAC_FIFO_BYPASS_EN enables empty pass-through
module dmac_fifo_param
  import dmac_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int AFULL_LVL  = 6,
  parameter int AEMPTY_LVL = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  dmac_fifo_param_if.slave bus
);

  localparam int                  DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH + 1)'(AFULL_LVL);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH + 1)'(AEMPTY_LVL);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  wr_err_q, wr_err_d;
  logic                  rd_ack_q, rd_ack_d;
  logic                  rd_err_q, rd_err_d;
  fifo_state_e           state_q, state_d;

  logic full, empty;
  logic wr_ok, rd_ok, bypass;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  // A write into a full FIFO is still accepted when a read frees the slot in the same cycle
  assign wr_ok = bus.wr_en & (~full | bus.rd_en);
`ifdef DMAC_FIFO_BYPASS_EN
  assign rd_ok  = bus.rd_en & (~empty | bus.wr_en);
  assign bypass = bus.wr_en & bus.rd_en & empty;
`else
  assign rd_ok  = bus.rd_en & ~empty;
  assign bypass = 1'b0;
`endif

  // Next pointers, occupancy, handshake pulses and status code from the pre-edge count
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wr_ack_d = wr_ok;
    wr_err_d = bus.wr_en & ~wr_ok;
    rd_ack_d = rd_ok;
    rd_err_d = bus.rd_en & ~rd_ok;
    state_d  = ST_IDLE;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (wr_ok && rd_ok)   state_d = ST_WR_RD;
    else if (wr_ok)       state_d = bus.rd_en ? ST_RD_ERROR : ST_WRITE;
    else if (rd_ok)       state_d = ST_READ;
    else if (bus.wr_en)   state_d = ST_WR_ERROR;
    else if (bus.rd_en)   state_d = ST_RD_ERROR;
  end

  // Control registers; requests arriving during reset are dropped
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wr_ack_q <= 1'b0;
      wr_err_q <= 1'b0;
      rd_ack_q <= 1'b0;
      rd_err_q <= 1'b0;
      state_q  <= ST_IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wr_ack_q <= wr_ack_d;
      wr_err_q <= wr_err_d;
      rd_ack_q <= rd_ack_d;
      rd_err_q <= rd_err_d;
      state_q  <= state_d;
    end
  end

  dmac_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk      (clk),
    .resetn   (reset_n),
    .we_i     (wr_ok & reset_n),
    .waddr_i  (wr_ptr_q),
    .wdata_i  (bus.din),
    .re_i     (rd_ok & reset_n),
    .raddr_i  (rd_ptr_q),
    .bypass_i (bypass),
    .rdata_o  (bus.dout)
  );

  assign bus.data_count   = count_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= AFULL_C);
  assign bus.almost_empty = (count_q <= AEMPTY_C);
  assign bus.wr_ack       = wr_ack_q;
  assign bus.wr_err       = wr_err_q;
  assign bus.rd_ack       = rd_ack_q;
  assign bus.rd_err       = rd_err_q;
  assign bus.state        = state_q;

endmodule
